muldiv_sequencer: RTL and testbench

//  Multi-cycle sequencer for RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU ops.

---
 rtl/muldiv_sequencer_if.sv | 24 ++
 rtl/muldiv_sequencer.sv | 166 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Handshake bundle between the control unit (master) and the RV32M multiply/divide sequencer.
interface muldiv_sequencer_if #(
   parameter int unsigned XLEN = 32
);
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] operand1;
   logic [XLEN-1:0] operand2;
   logic            flush;
   logic [XLEN-1:0] result;
   logic            busy;
   logic            done;
   logic            stall;

   modport master (
      output start, funct3, operand1, operand2, flush,
      input  result, busy, done, stall
   );

   modport slave (
      input  start, funct3, operand1, operand2, flush,
      output result, busy, done, stall
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M sequencer: shift-add multiply, restoring divide, special cases in FIXUP.
// Define MULDIV_FAST_MUL_EN to compute multiplies with a single-cycle wide product instead.
module muldiv_sequencer #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned COUNT_W = 6
) (
   input logic               clk,
   input logic               rst,
   muldiv_sequencer_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StCalc, StFixup, StDoneS} state_e;

   localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

   state_e             state_q, state_d;
   logic [2:0]         op_q, op_d;
   logic               neg_q, neg_d;
   logic               special_q, special_d;
   logic [XLEN-1:0]    a_q, a_d;
   logic [XLEN-1:0]    result_q, result_d;
   logic [2*XLEN-1:0]  acc_q, acc_d;
   logic [COUNT_W-1:0] cnt_q, cnt_d;
   logic               busy_q, done_q;

   logic               div_op, sgn1, sgn2, neg1, neg2, div_zero, div_ovf;
   logic [XLEN-1:0]    abs1, abs2, special_val;

   assign div_op   = bus.funct3[2];
   assign sgn1     = (bus.funct3 == 3'b001) | (bus.funct3 == 3'b010) |
                     (bus.funct3 == 3'b100) | (bus.funct3 == 3'b110);
   assign sgn2     = (bus.funct3 == 3'b001) | (bus.funct3 == 3'b100) | (bus.funct3 == 3'b110);
   assign neg1     = sgn1 & bus.operand1[XLEN-1];
   assign neg2     = sgn2 & bus.operand2[XLEN-1];
   assign abs1     = neg1 ? -bus.operand1 : bus.operand1;
   assign abs2     = neg2 ? -bus.operand2 : bus.operand2;
   assign div_zero = div_op & (bus.operand2 == '0);
   assign div_ovf  = div_op & ~bus.funct3[0] & (bus.operand1 == MinInt) & (bus.operand2 == '1);

   always_comb begin
      if (div_zero) special_val = bus.funct3[1] ? bus.operand1 : '1;
      else          special_val = bus.funct3[1] ? '0 : MinInt;
   end

   // acc = {partial product high, multiplier} for multiply, {remainder, dividend/quotient} for divide
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     rem_sh;
   logic              div_ge;
   logic [XLEN-1:0]   div_diff;
   logic [2*XLEN-1:0] mul_next, div_next;

   assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
   assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
   assign rem_sh   = acc_q[2*XLEN-1:XLEN-1];
   assign div_ge   = rem_sh >= {1'b0, a_q};
   assign div_diff = rem_sh[XLEN-1:0] - a_q;
   assign div_next = div_ge ? {div_diff, acc_q[XLEN-2:0], 1'b1}
                            : {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

   logic [2*XLEN-1:0] prod_mag, prod;
   logic [XLEN-1:0]   quo_mag, rem_mag, quo, rem, fix_val;

`ifdef MULDIV_FAST_MUL_EN
   assign prod_mag = {{XLEN{1'b0}}, a_q} * {{XLEN{1'b0}}, acc_q[XLEN-1:0]};
`else
   assign prod_mag = acc_q;
`endif
   assign prod    = neg_q ? -prod_mag : prod_mag;
   assign quo_mag = acc_q[XLEN-1:0];
   assign rem_mag = acc_q[2*XLEN-1:XLEN];
   assign quo     = neg_q ? -quo_mag : quo_mag;
   assign rem     = neg_q ? -rem_mag : rem_mag;

   always_comb begin
      if (special_q)            fix_val = acc_q[XLEN-1:0];
      else if (op_q == 3'b000)  fix_val = prod[XLEN-1:0];
      else if (!op_q[2])        fix_val = prod[2*XLEN-1:XLEN];
      else if (!op_q[1])        fix_val = quo;
      else                      fix_val = rem;
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      neg_d     = neg_q;
      special_d = special_q;
      a_d       = a_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      if (bus.flush) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  op_d      = bus.funct3;
                  // REM result follows the dividend; everything else follows the sign product
                  neg_d     = (div_op & bus.funct3[1]) ? neg1 : (neg1 ^ neg2);
                  special_d = div_zero | div_ovf;
                  a_d       = div_op ? abs2 : abs1;
                  acc_d     = {{XLEN{1'b0}}, (div_op ? abs1 : abs2)};
                  if (div_zero | div_ovf) begin
                     acc_d   = {{XLEN{1'b0}}, special_val};
                     state_d = StFixup;
                  end
`ifdef MULDIV_FAST_MUL_EN
                  else if (!div_op) begin
                     state_d = StFixup;
                  end
`endif
                  else begin
                     cnt_d   = COUNT_W'(XLEN - 1);
                     state_d = StCalc;
                  end
               end
            end
            StCalc: begin
               acc_d = op_q[2] ? div_next : mul_next;
               if (cnt_q == '0) state_d = StFixup;
               else             cnt_d   = cnt_q - 1'b1;
            end
            StFixup: begin
               result_d = fix_val;
               state_d  = StDoneS;
            end
            StDoneS: begin
               state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         op_q      <= '0;
         neg_q     <= 1'b0;
         special_q <= 1'b0;
         a_q       <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         neg_q     <= neg_d;
         special_q <= special_d;
         a_q       <= a_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         result_q  <= result_d;
         busy_q    <= (state_d != StIdle);
         done_q    <= (state_d == StDoneS);
      end
   end

   assign bus.result = result_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.stall  = (bus.start & (state_q == StIdle)) | (busy_q & ~done_q);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer (honours MULDIV_FAST_MUL_EN for multiply latency).
module tb_muldiv_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MulLat = 2;
`else
   localparam int MulLat = 34;
`endif
   localparam int DivLat = 34;
   localparam int SpcLat = 2;

   muldiv_sequencer_if #(.XLEN(32)) bus ();

   muldiv_sequencer #(.XLEN(32), .COUNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Launch one op, then follow it to DONE, checking latency, result and stall behaviour.
   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
      int   lat;
      logic stall_ok;
      bus.funct3   = f3;
      bus.operand1 = a;
      bus.operand2 = b;
      bus.start    = 1'b1;
      #1;
      check({tag, "_stall_c0"}, 32'(bus.stall), 32'd1);
      lat      = 0;
      stall_ok = 1'b1;
      do begin
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         lat++;
         if (!bus.done && !bus.stall) stall_ok = 1'b0;
      end while (!bus.done && lat < 100);
      check({tag, "_done"},     32'(bus.done),  32'd1);
      check({tag, "_latency"},  32'(lat),       32'(exp_lat));
      check({tag, "_result"},   bus.result,     exp_res);
      check({tag, "_stall_dn"}, 32'(bus.stall), 32'd0);
      check({tag, "_stall_hi"}, 32'(stall_ok),  32'd1);
      @(posedge clk);
      #1;
      check({tag, "_idle"},     32'(bus.busy),  32'd0);
   endtask

   initial begin
      int dcount;
      bus.start    = 1'b0;
      bus.flush    = 1'b0;
      bus.funct3   = 3'b000;
      bus.operand1 = '0;
      bus.operand2 = '0;

      #12;
      check("rst_result", bus.result,        32'd0);
      check("rst_busy",   32'(bus.busy),     32'd0);
      check("rst_done",   32'(bus.done),     32'd0);
      check("rst_stall",  32'(bus.stall),    32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      run_op("mul",      3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, MulLat);
      run_op("div_neg",  3'b100, 32'hFFFF_FFEC, 32'd3,       32'hFFFF_FFFA, DivLat);
      run_op("rem_neg",  3'b110, 32'hFFFF_FFEC, 32'd3,       32'hFFFF_FFFE, DivLat);
      run_op("divu",     3'b101, 32'd100,      32'd7,        32'd14,        DivLat);
      run_op("remu",     3'b111, 32'd100,      32'd7,        32'd2,         DivLat);
      run_op("div_7_m2", 3'b100, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, DivLat);
      run_op("rem_7_m2", 3'b110, 32'd7,        32'hFFFF_FFFE, 32'd1,         DivLat);
      run_op("divu_z",   3'b101, 32'd5,        32'd0,        32'hFFFF_FFFF, SpcLat);
      run_op("rem_z",    3'b110, 32'd5,        32'd0,        32'd5,         SpcLat);
      run_op("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SpcLat);
      run_op("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         SpcLat);
      run_op("mulhu",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MulLat);
      run_op("mulhsu",   3'b010, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, MulLat);
      run_op("mulh",     3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MulLat);

      // Flush in cycle 10 of a divide: no DONE, result keeps the MULH value.
      bus.funct3   = 3'b100;
      bus.operand1 = 32'd100;
      bus.operand2 = 32'd7;
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      check("flush_busy_pre", 32'(bus.busy), 32'd1);
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      check("flush_busy", 32'(bus.busy), 32'd0);
      dcount = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.done) dcount++;
      end
      check("flush_no_done", 32'(dcount),  32'd0);
      check("flush_result",  bus.result,   32'h4000_0000);

      // Flush and start together in IDLE: nothing launches.
      bus.funct3 = 3'b101;
      bus.start  = 1'b1;
      bus.flush  = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      check("flstart_busy", 32'(bus.busy), 32'd0);
      dcount = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.done) dcount++;
      end
      check("flstart_no_done", 32'(dcount), 32'd0);

      // A second START while busy is dropped: one DONE carrying the DIVU result.
      bus.funct3   = 3'b101;
      bus.operand1 = 32'd100;
      bus.operand2 = 32'd7;
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      bus.funct3   = 3'b000;
      bus.operand1 = 32'd3;
      bus.operand2 = 32'd3;
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      dcount = 0;
      repeat (45) begin
         @(posedge clk);
         #1;
         if (bus.done) dcount++;
      end
      check("busy_start_dones", 32'(dcount),   32'd1);
      check("busy_start_res",   bus.result,    32'd14);
      check("busy_start_idle",  32'(bus.busy), 32'd0);

      // Asynchronous reset in the middle of a multiply.
      bus.funct3   = 3'b000;
      bus.operand1 = 32'd7;
      bus.operand2 = 32'hFFFF_FFFD;
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      check("mid_busy", 32'(bus.busy), 32'(MulLat > 6));
      #3;
      rst = 1'b1;
      #1;
      check("async_rst_result", bus.result,    32'd0);
      check("async_rst_busy",   32'(bus.busy), 32'd0);
      check("async_rst_done",   32'(bus.done), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      run_op("mul_after_rst", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MulLat);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
